fetch_sequencer: RTL

Instruction-fetch controller that sequences the word-addressed instruction memory for the pipelined core. It owns the PC and issues byte addresses (multiples of 4) with a req/ready handshake. It also manages the IF/ID pipeline register. It handles pipeline freeze (hazard stall), taken-branch redirect/flush, and slow memory responses; for the current combinational instruction memory, imem_ready is tied high.

---
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory fetch bus.
//   master (fetch side)  : drives imem_req, imem_addr; samples imem_rdata, imem_ready
//   slave  (memory side) : samples imem_req, imem_addr; drives imem_rdata, imem_ready
// A fetch is accepted on a rising edge where imem_req and imem_ready are both high.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the pipelined core.
// Owns the PC, issues word-aligned fetch addresses over the imem bus and
// maintains the IF/ID pipeline register. Handles hazard freeze, taken-branch
// redirect/flush and slow memory responses.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   freeze         : hazard stall from ID, holds PC and IF/ID
//   branch_taken   : redirect from EX, flushes IF/ID
//   branch_addr    : redirect target byte address (low bits ignored)
//   imem           : fetch bus (master side)
//   if_valid       : IF/ID holds a real instruction
//   if_instr       : IF/ID instruction word
//   if_pc          : IF/ID PC+4 of that instruction
module fetch_sequencer #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
    parameter int              PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    fetch_sequencer_if.master   imem,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [ADDR_W-1:0]   if_pc
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Clears the two byte-offset bits so every PC is word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(PC_STEP);

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_seq_s;
    logic [ADDR_W-1:0] branch_aligned_s;
    logic [31:0]       hold_instr_r;
    logic              if_valid_r;
    logic [31:0]       if_instr_r;
    logic [ADDR_W-1:0] if_pc_r;
    logic              req_s;
    logic              accept_s;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_seq_s         = pc_r + STEP_W;
    assign branch_aligned_s = branch_addr & ALIGN_MASK;
    assign accept_s         = req_s & imem.imem_ready;

    assign if_valid = if_valid_r;
    assign if_instr = if_instr_r;
    assign if_pc    = if_pc_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a taken branch always returns to FETCH.
    always_comb begin
        state_next_s = state_r;
        if (branch_taken) begin
            state_next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (accept_s && freeze) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                default: state_next_s = ST_FETCH;
            endcase
        end
    end

    // Bus outputs: request only in FETCH and never while reset is asserted.
    always_comb begin
        req_s          = 1'b0;
        imem.imem_addr = pc_r & ALIGN_MASK;
        if (rst) begin
            req_s = 1'b0;
        end else if (state_r == ST_FETCH) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        imem.imem_req = req_s;
    end

    // PC, IF/ID register and hold buffer; reset beats branch beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC & ALIGN_MASK;
            if_valid_r   <= 1'b0;
            if_instr_r   <= 32'd0;
            if_pc_r      <= '0;
            hold_instr_r <= 32'd0;
        end else if (branch_taken) begin
            // Flush: any word accepted this cycle is dropped.
            pc_r         <= branch_aligned_s;
            if_valid_r   <= 1'b0;
            if_instr_r   <= 32'd0;
            if_pc_r      <= '0;
            hold_instr_r <= 32'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (accept_s) begin
                        if (freeze) begin
                            // Park the word until ID can take it.
                            hold_instr_r <= imem.imem_rdata;
                        end else begin
                            if_instr_r <= imem.imem_rdata;
                            if_pc_r    <= pc_seq_s;
                            if_valid_r <= 1'b1;
                            pc_r       <= pc_seq_s;
                        end
                    end else if (!freeze) begin
                        // Memory not ready: insert a bubble.
                        if_valid_r <= 1'b0;
                    end else begin
                        if_valid_r <= if_valid_r;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        if_instr_r <= hold_instr_r;
                        if_pc_r    <= pc_seq_s;
                        if_valid_r <= 1'b1;
                        pc_r       <= pc_seq_s;
                    end else begin
                        if_valid_r <= if_valid_r;
                    end
                end
                default: begin
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
